loop_step_driver: RTL and testbench

Drives a two-digit dekatron loop counter to a requested BCD value by issuing Step pulses with the correct Reverse direction. It closes the loop through the counter's 8-4-2-1 output. It sits between the sequencer, which requests "set loop count to N", and the loop counter, which only understands Step, Reverse and reset.

---
 rtl/loop_step_driver.sv | 212 +++++++++++++++++++++
 tb/tb_loop_step_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/loop_step_driver.sv
// -----------------------------------------------------------------------------
// loop_step_driver
//
// Drives a two-digit dekatron loop counter to a requested BCD value. It issues
// Step pulses with a fixed Reverse direction. The loop is closed through the
// counter's 8-4-2-1 BCD output, which is fed back on i_current.
//
// Parameters
//   STEP_HIGH  cycles o_step is held high per pulse (>= 1)
//   STEP_LOW   cycles o_step is held low after each high phase (>= 1)
//   MAX_STEPS  pulse budget per request before o_error is raised (<= 127)
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_start    request strobe, sampled only in IDLE
//   i_target   requested BCD value, [7:4] tens, [3:0] units
//   i_current  counter BCD output, fed back
//   o_step     step pulse to the counter (counter advances on its rising edge)
//   o_reverse  counting direction to the counter, 1 = count down
//   o_busy     high while a request is in progress
//   o_done     one-cycle pulse when the counter has reached the target
//   o_error    one-cycle pulse on an invalid target or an exhausted budget
//
// Optional feature
//   LOOP_STEP_DRIVER_WRAP_EN  when defined, the driver takes the short way
//                             around through 99<->00 if the distance is
//                             greater than 50.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for i_start; validates and latches the target
// SETUP    | compares target with counter, chooses direction
// PULSE_HI | o_step high, STEP_HIGH cycles
// PULSE_LO | o_step low, STEP_LOW cycles, then the pulse is counted
// CHECK    | compares counter with target, enforces the pulse budget
// DONE     | o_done pulse, return to IDLE
// -----------------------------------------------------------------------------
module loop_step_driver #(
   parameter int STEP_HIGH = 1,
   parameter int STEP_LOW  = 1,
   parameter int MAX_STEPS = 100
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_target,
   input  logic [7:0] i_current,
   output logic       o_step,
   output logic       o_reverse,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE_HI,
      S_PULSE_LO,
      S_CHECK,
      S_DONE
   } state_t;

   localparam int TMAX = (STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

   localparam logic [TW-1:0] HI_LOAD = TW'(STEP_HIGH - 1);
   localparam logic [TW-1:0] LO_LOAD = TW'(STEP_LOW - 1);
   localparam logic [6:0]    MAX_CNT = 7'(MAX_STEPS);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_tgt;
   logic [7:0]      w_tgt_nxt;
   logic [6:0]      r_cnt;
   logic [6:0]      w_cnt_nxt;
   logic [TW-1:0]   r_tmr;
   logic [TW-1:0]   w_tmr_nxt;
   logic            r_rev;
   logic            w_rev_nxt;
   logic            r_err;
   logic            w_err_nxt;

   logic [6:0]      w_tgt_bin;
   logic [6:0]      w_cur_bin;
   logic [6:0]      w_dist;
   logic            w_toward;
   logic            w_rev_calc;
   logic            w_tgt_valid;

   function automatic logic [6:0] bcd2bin(input logic [7:0] b);
      return ({3'b000, b[7:4]} * 7'd10) + {3'b000, b[3:0]};
   endfunction

   assign w_tgt_bin   = bcd2bin(r_tgt);
   assign w_cur_bin   = bcd2bin(i_current);
   assign w_toward    = (w_tgt_bin < w_cur_bin);
   assign w_dist      = w_toward ? (w_cur_bin - w_tgt_bin) : (w_tgt_bin - w_cur_bin);
   assign w_tgt_valid = (i_target[7:4] <= 4'd9) && (i_target[3:0] <= 4'd9);

`ifdef LOOP_STEP_DRIVER_WRAP_EN
   // Going the long way is more than half the loop; wrapping is shorter.
   assign w_rev_calc = (w_dist > 7'd50) ? ~w_toward : w_toward;
`else
   assign w_rev_calc = w_toward;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_tgt   <= 8'h00;
         r_cnt   <= 7'd0;
         r_tmr   <= '0;
         r_rev   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tgt   <= w_tgt_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tmr   <= w_tmr_nxt;
         r_rev   <= w_rev_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tgt_nxt   = r_tgt;
      w_cnt_nxt   = r_cnt;
      w_tmr_nxt   = r_tmr;
      w_rev_nxt   = r_rev;
      w_err_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_tgt_nxt = i_target;
               if (w_tgt_valid) begin
                  w_state_nxt = S_SETUP;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end

         S_SETUP: begin
            if (w_dist == 7'd0) begin
               w_state_nxt = S_DONE;
            end else begin
               w_rev_nxt   = w_rev_calc;
               w_cnt_nxt   = 7'd0;
               w_tmr_nxt   = HI_LOAD;
               w_state_nxt = S_PULSE_HI;
            end
         end

         S_PULSE_HI: begin
            if (r_tmr == '0) begin
               w_tmr_nxt   = LO_LOAD;
               w_state_nxt = S_PULSE_LO;
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end

         S_PULSE_LO: begin
            if (r_tmr == '0) begin
               if (r_cnt != MAX_CNT) begin
                  w_cnt_nxt = r_cnt + 7'd1;
               end
               w_state_nxt = S_CHECK;
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end

         S_CHECK: begin
            if (i_current == r_tgt) begin
               w_state_nxt = S_DONE;
            end else if (r_cnt == MAX_CNT) begin
               w_err_nxt   = 1'b1;
               w_rev_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end else begin
               w_tmr_nxt   = HI_LOAD;
               w_state_nxt = S_PULSE_HI;
            end
         end

         S_DONE: begin
            w_rev_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Step and Busy decode straight from the state register, so the async
   // reset of the state pulls them low immediately. Reverse is presented
   // during SETUP from the live comparison so it leads the first Step
   // rising edge by a full cycle; afterwards it comes from the latched copy.
   assign o_step    = (r_state == S_PULSE_HI);
   assign o_busy    = (r_state != S_IDLE);
   assign o_done    = (r_state == S_DONE);
   assign o_error   = r_err;
   assign o_reverse = (r_state == S_SETUP) ? w_rev_calc : r_rev;

endmodule

// File: tb/tb_loop_step_driver.sv
module tb_loop_step_driver;

   localparam int P = 1 + 1 + 1;  // STEP_HIGH + STEP_LOW + CHECK, defaults

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] target = 8'h00;
   logic [7:0] current;
   logic       step, reverse, busy, done, error;

   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  start_cyc = -1000;

   typedef struct {
      bit is_err;
      int ecyc;
      int pulses;
      bit rev;
   } exp_t;
   exp_t q[$];

   loop_step_driver dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_target  (target),
      .i_current (current),
      .o_step    (step),
      .o_reverse (reverse),
      .o_busy    (busy),
      .o_done    (done),
      .o_error   (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // dekatron counter model, BCD 00..99 with wrap
   int  cur_v = 0;
   int  load_val = 0;
   bit  load = 1'b0;
   bit  conn = 1'b1;
   always @(posedge step or posedge load) begin
      if (load) cur_v <= load_val;
      else if (conn) cur_v <= reverse ? (cur_v + 99) % 100 : (cur_v + 1) % 100;
   end
   assign current = 8'(((cur_v / 10) * 16) + (cur_v % 10));

   function automatic int b2i(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // monitor / scoreboard
   int   rel;
   int   pulses = 0;
   bit   rev_seen = 0;
   bit   rev_bad = 0;
   bit   prev_step = 0;
   bit   prev_rev = 0;
   bit   busy_chk = 0;
   exp_t e;
   always @(negedge clk) begin
      if (!rst) begin
         rel = cyc - start_cyc;
         if (rel == 1) begin
            pulses  = 0;
            rev_bad = 0;
            rev_seen = 0;
         end
         if (step && !prev_step) pulses++;
         if (step) begin
            rev_seen = reverse;
            if (reverse != prev_rev) rev_bad = 1;
         end
         if (busy_chk) begin
            check("busy_after_end", int'(busy), 0);
            busy_chk = 0;
         end
         if (done || error) begin
            if (q.size() == 0) begin
               check("unexpected_done_error", 1, 0);
            end else begin
               e = q.pop_front();
               check("kind_done_error", int'({done, error}), int'({~e.is_err, e.is_err}));
               check("end_cycle", rel, e.ecyc);
               check("pulse_count", pulses, e.pulses);
               if (e.pulses > 0) begin
                  check("reverse_value", int'(rev_seen), int'(e.rev));
                  check("reverse_stable", int'(rev_bad), 0);
               end
               busy_chk = 1;
            end
         end
         prev_step = step;
         prev_rev  = reverse;
      end
   end

   task automatic wait_idle();
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      if (q.size() != 0) begin
         check("timeout_waiting_end", 0, 1);
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run(input logic [7:0] cur, input logic [7:0] tgt, input bit c,
                      input bit is_err, input bit invalid, input int np, input bit rev,
                      input bit extra_start);
      exp_t x;
      @(negedge clk);
      conn = c;
      load_val = b2i(cur);
      load = 1'b1;
      #1 load = 1'b0;
      x.is_err = is_err;
      x.ecyc   = invalid ? 1 : 2 + np * P;
      x.pulses = np;
      x.rev    = rev;
      q.push_back(x);
      target    = tgt;
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start  = 1'b0;
      target = 8'h99;  // must be ignored after acceptance
      if (extra_start) begin
         repeat (3) @(negedge clk);
         target = 8'h09;
         start  = 1'b1;
         @(negedge clk);
         start  = 1'b0;
      end
      wait_idle();
   endtask

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      check("reset_step", int'(step), 0);
      check("reset_reverse", int'(reverse), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done_error", int'({done, error}), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run(8'h00, 8'h05, 1, 0, 0, 5, 0, 0);
      run(8'h42, 8'h17, 1, 0, 0, 25, 1, 0);
`ifdef LOOP_STEP_DRIVER_WRAP_EN
      run(8'h95, 8'h03, 1, 0, 0, 8, 0, 0);
      run(8'h00, 8'h51, 1, 0, 0, 49, 1, 0);
`else
      run(8'h95, 8'h03, 1, 0, 0, 92, 1, 0);
      run(8'h00, 8'h51, 1, 0, 0, 51, 0, 0);
`endif
      run(8'h00, 8'h50, 1, 0, 0, 50, 0, 0);
      run(8'h98, 8'h99, 1, 0, 0, 1, 0, 0);
      run(8'h00, 8'h3A, 1, 1, 1, 0, 0, 0);
      run(8'h00, 8'hA3, 1, 1, 1, 0, 0, 0);
      run(8'h27, 8'h27, 1, 0, 0, 0, 0, 0);
      run(8'h00, 8'h10, 0, 1, 0, 100, 0, 0);
      run(8'h00, 8'h03, 1, 0, 0, 3, 0, 1);

      // reset during PULSE_HI
      @(negedge clk);
      conn = 1'b1;
      load_val = 50;
      load = 1'b1;
      #1 load = 1'b0;
      target    = 8'h20;
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         if (step) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      check("reach_pulse_hi", int'(seen), 1);
      check("reverse_before_rst", int'(reverse), 1);
      rst = 1'b1;
      #1;
      check("rst_step", int'(step), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_reverse", int'(reverse), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_rst", int'({busy, step}), 0);
      run(8'h20, 8'h22, 1, 0, 0, 2, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
